// File: rtl/weight_loader.sv
// Weight-memory write-side loader: takes a valid/ready byte stream and issues one
// registered write per accepted byte to consecutive addresses starting at base_addr.
module weight_loader #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH:0]   span;
  logic                  range_bad;

  // One extra bit so base+count cannot wrap before the DEPTH comparison.
  always_comb begin
    span      = {1'b0, base_addr} + (ADDR_WIDTH+1)'(count);
    range_bad = (span > DEPTH_EXT);
  end

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      error     <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (range_bad) begin
              error <= 1'b1;
              state <= DONE;
            end else if (count == '0) begin
              error <= 1'b0;
              state <= DONE;
            end else begin
              error     <= 1'b0;
              cur_addr  <= base_addr;
              remaining <= count;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= cur_addr;
            mem_wdata <= in_data;
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: transaction-level reference model compared
// every cycle, plus literal expectations on the memory image after each load.
module tb_weight_loader;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] count;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  weight_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending beats of the current load, next write address,
  // and what the outputs must show in the cycle following each edge.
  int m_pending   = 0;
  int m_next_addr = 0;
  int m_addr      = 0;
  int m_data      = 0;
  bit m_we        = 1'b0;
  bit m_done      = 1'b0;
  bit m_err       = 1'b0;
  bit was_done;

  always @(posedge clk) begin
    if (reset) begin
      m_pending = 0; m_next_addr = 0; m_addr = 0; m_data = 0;
      m_we = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      was_done = m_done;
      m_we     = 1'b0;
      m_done   = 1'b0;
      if (m_pending == 0 && !was_done) begin
        if (start) begin
          if (int'(base_addr) + int'(count) > DEPTH) begin
            m_err = 1'b1; m_done = 1'b1;
          end else if (count == 0) begin
            m_err = 1'b0; m_done = 1'b1;
          end else begin
            m_err = 1'b0; m_pending = int'(count); m_next_addr = int'(base_addr);
          end
        end
      end else if (m_pending > 0 && in_valid) begin
        m_we = 1'b1;
        m_addr = m_next_addr;
        m_data = int'(in_data);
        m_next_addr++;
        m_pending--;
        if (m_pending == 0) m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  in_ready,  m_pending > 0);
      chk("mem_we",    mem_we,    m_we);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_data);
      chk("busy",      busy,      (m_pending > 0) || m_done);
      chk("done",      done,      m_done);
      chk("error",     error,     m_err);
    end
  end

  // Captured image of DUT writes, inspected only after loads settle.
  logic [7:0] dut_mem [0:31];
  int wr_cnt = 0;

  always @(negedge clk) begin
    if (chk_en && mem_we === 1'b1) begin
      wr_cnt++;
      if (mem_addr < 32) dut_mem[mem_addr[4:0]] = mem_wdata;
    end
  end

  logic [7:0] src [$];
  bit         vpat [$];

  task automatic do_start(input int b, input int c);
    start = 1'b1;
    base_addr = AW'(b);
    count = CW'(c);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int budget);
    int idx;
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < budget) begin
      in_valid = (vpat.size() == 0) ? 1'b1 : vpat[cyc % vpat.size()];
      in_data  = src[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("feed_complete", idx, n);
  endtask

  task automatic wait_done(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
    end
    chk("done_seen", found, 1);
    @(posedge clk); #1;
  endtask

  int w0;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 32; i++) dut_mem[i] = 8'h00;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic streaming
    w0 = wr_cnt;
    src = '{8'h11, 8'h22, 8'h33, 8'h44}; vpat = {};
    do_start(0, 4);
    feed(4, 20);
    wait_done(10);
    chk("basic_writes", wr_cnt - w0, 4);
    chk("basic_m0", dut_mem[0], 8'h11);
    chk("basic_m1", dut_mem[1], 8'h22);
    chk("basic_m2", dut_mem[2], 8'h33);
    chk("basic_m3", dut_mem[3], 8'h44);

    // Bubbles on in_valid
    w0 = wr_cnt;
    src = '{8'hAA, 8'hBB, 8'hCC}; vpat = '{1, 0, 0, 1, 0, 1};
    do_start(8, 3);
    feed(3, 20);
    wait_done(10);
    vpat = {};
    chk("bub_writes", wr_cnt - w0, 3);
    chk("bub_m8", dut_mem[8], 8'hAA);
    chk("bub_m9", dut_mem[9], 8'hBB);
    chk("bub_m10", dut_mem[10], 8'hCC);

    // Out-of-range start is rejected with done at S+1
    w0 = wr_cnt;
    do_start(30, 3);
    @(negedge clk);
    chk("rej_done", done, 1);
    chk("rej_error", error, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rej_writes", wr_cnt - w0, 0);

    // Exact fit at the top of memory
    w0 = wr_cnt;
    src = '{8'h29, 8'h30, 8'h31};
    do_start(29, 3);
    chk("fit_error_clr", error, 0);
    feed(3, 20);
    wait_done(10);
    chk("fit_writes", wr_cnt - w0, 3);
    chk("fit_m29", dut_mem[29], 8'h29);
    chk("fit_m31", dut_mem[31], 8'h31);

    // Zero count
    w0 = wr_cnt;
    do_start(5, 0);
    wait_done(3);
    chk("zero_writes", wr_cnt - w0, 0);

    // Full-depth load
    w0 = wr_cnt;
    src = {};
    for (int i = 0; i < 32; i++) src.push_back(8'((i * 7 + 3) & 8'hFF));
    do_start(0, 32);
    feed(32, 60);
    wait_done(10);
    chk("full_writes", wr_cnt - w0, 32);
    chk("full_m0", dut_mem[0], 8'h03);
    chk("full_m31", dut_mem[31], 8'hDC);

    // start during an active load is ignored
    w0 = wr_cnt;
    do_start(0, 4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h50 + i);
      start = (i == 1);
      base_addr = AW'(16);
      count = CW'(2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0;
    wait_done(5);
    chk("ign_writes", wr_cnt - w0, 4);
    chk("ign_m0", dut_mem[0], 8'h50);
    chk("ign_m3", dut_mem[3], 8'h53);

    // Reset in the middle of a load
    w0 = wr_cnt;
    do_start(0, 8);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h60 + i);
      @(posedge clk); #1;
    end
    in_data = 8'h63;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mr_mem_we", mem_we, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mr_writes", wr_cnt - w0, 3);
    chk("mr_m2", dut_mem[2], 8'h62);

    // New load after reset
    w0 = wr_cnt;
    src = '{8'h71, 8'h72};
    do_start(4, 2);
    feed(2, 10);
    wait_done(10);
    chk("post_writes", wr_cnt - w0, 2);
    chk("post_m4", dut_mem[4], 8'h71);
    chk("post_m5", dut_mem[5], 8'h72);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
# weight_loader

Write-side companion to the weight memory: accepts a byte stream of weights over a valid/ready handshake and issues one registered write per byte into consecutive weight-memory addresses starting at a programmed base. It sits between the host/instruction path and the weight memory's write port, so the systolic array's 4-wide weight reads find populated locations. One load transaction is started by a `start` pulse and finishes with a one-cycle `done` pulse.

## Interface
- `ADDR_WIDTH`, default 13: width of weight-memory address.
- `DATA_WIDTH`, default 8: weight width.
- `DEPTH`, default 32: number of weight-memory entries; last legal address is DEPTH-1.
- `CNT_WIDTH`, default 6: width of `count`; must hold DEPTH.

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first write address; sampled with `start`.
- `count`  in  CNT_WIDTH  number of weights to load; sampled with `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  DATA_WIDTH  weight byte.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `mem_we`  out  1  write strobe to weight memory (registered).
- `mem_addr`  out  ADDR_WIDTH  write address (registered).
- `mem_wdata`  out  DATA_WIDTH  write data (registered).
- `busy`  out  1  high in LOAD and DONE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  last start was rejected; held until next accepted `start` or reset.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: `in_ready`=0, `busy`=0. On `start`:
  - Range check in ADDR_WIDTH+1-bit arithmetic: zero-extended `base_addr` + `count` > DEPTH -> reject: `error`<=1, go DONE, no writes.
  - `count`==0 -> go DONE, `error`<=0, no writes.
  - Otherwise: latch cur_addr=`base_addr`, remaining=`count`, `error`<=0, go LOAD.
- LOAD: `in_ready`=1 (decoded from state, combinational). Beat accepted when `in_valid && in_ready`:
  - next cycle `mem_we`=1, `mem_addr`=cur_addr, `mem_wdata`=`in_data`.
  - cur_addr+1, remaining-1.
  - If remaining was 1 -> go DONE.
  - No accepted beat -> `mem_we`=0 next cycle; bubbles on `in_valid` allowed indefinitely.
- DONE: `done`=1 for exactly this cycle, `in_ready`=0, `busy`=1; next state IDLE unconditionally.
- `start` in LOAD or DONE is ignored; `base_addr`/`count` changes after sampling have no effect.
- `in_data` presented while `in_ready`=0 is not consumed; source must hold it.
- Addresses never wrap: range check guarantees last write address ≤ DEPTH-1.
- Writes strictly in order, one per accepted beat, exactly `count` writes per accepted load.

## Timing
- Reset (synchronous): state IDLE; `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0; internal counters 0.
- Reset mid-LOAD: no write strobe in the cycle after reset; writes already issued stay in memory; bytes not yet accepted are lost.
- `start` at cycle S -> `in_ready`=1 at S+1.
- Beat accepted at cycle N -> `mem_we` at N+1.
- Last beat accepted at N -> final `mem_we` and `done` both at N+1 (memory commits it at the edge ending N+1); `in_ready`=0 at N+1; IDLE at N+2; next `start` sampled at N+2.
- Rejected or zero-count start at S -> `done` at S+1 (with `error`=1 if rejected), IDLE at S+2.
- Back-to-back streaming with `in_valid` held high: one write per cycle, load of K bytes takes K+2 cycles from `start` to return to IDLE.

## Test plan
- Basic: reset, `start` with base=0, count=4, stream 0x11,0x22,0x33,0x44 with `in_valid` held -> writes (0,0x11),(1,0x22),(2,0x33),(3,0x44) on consecutive cycles, `done` with last write, `error`=0.
- Bubbles: base=8, count=3, `in_valid` toggled 1,0,0,1,0,1 -> exactly 3 writes to 8,9,10, `mem_we` low on idle cycles, data order preserved.
- Range: base=30, count=3 -> `error`=1, `done` at S+1, zero `mem_we`; then base=29, count=3 -> accepted, writes 29..31, `error` clears.
- Zero/full: count=0 -> `done` only, no writes; base=0, count=32 -> 32 writes, last address 31.
- Ignore start: pulse `start` with base=16 during an active load at base=0 -> load continues at base 0, no restart.
- Reset mid-load: count=8, reset after 3 accepted beats -> all outputs 0 next cycle, no further `mem_we`, `in_ready`=0; new load after reset works normally.
